// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction-RAM arbiter: response-owner encoding and
// request-port indices.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_P0     = 2'd1,
    OWN_P1     = 2'd2,
    OWN_P1_ERR = 2'd3
  } owner_e;

  localparam bit PORT_P0 = 1'b0;
  localparam bit PORT_P1 = 1'b1;

endpackage

// File: rtl/instr_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the instruction RAM.
// slave = arbiter view, master = requesters + RAM view.
interface instr_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    p0_req_i;
  logic                    p0_gnt_o;
  logic [ADDR_WIDTH-1:0]   p0_addr_i;
  logic                    p0_rvalid_o;
  logic [DATA_WIDTH-1:0]   p0_rdata_o;

  logic                    p1_req_i;
  logic                    p1_gnt_o;
  logic                    p1_we_i;
  logic [DATA_WIDTH/8-1:0] p1_be_i;
  logic [ADDR_WIDTH-1:0]   p1_addr_i;
  logic [DATA_WIDTH-1:0]   p1_wdata_i;
  logic                    p1_rvalid_o;
  logic [DATA_WIDTH-1:0]   p1_rdata_o;
  logic                    p1_err_o;

  logic                    ram_en_o;
  logic                    ram_we_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic [DATA_WIDTH-1:0]   ram_wdata_o;
  logic [DATA_WIDTH/8-1:0] ram_be_o;
  logic [DATA_WIDTH-1:0]   ram_rdata_i;

  modport slave (
    input  p0_req_i, p0_addr_i,
    output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
    input  p1_req_i, p1_we_i, p1_be_i, p1_addr_i, p1_wdata_i,
    output p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
    input  ram_rdata_i
  );

  modport master (
    output p0_req_i, p0_addr_i,
    input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
    output p1_req_i, p1_we_i, p1_be_i, p1_addr_i, p1_wdata_i,
    input  p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/instr_ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the port preferred on the
// next contested cycle and moves only when both ports request.
module instr_rr_arb2
  import instr_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (&req_i) begin
      gnt_o[ptr_q] = 1'b1;
      ptr_d        = ~ptr_q;
    end else begin
      gnt_o = req_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PORT_P0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/instr_ram_arbiter.sv
// Instruction-RAM arbiter: read-only fetch port p0 and loader port p1 share one
// single-cycle RAM. Define INSTR_ARB_RR_EN for round-robin, else p1 has priority.
module instr_ram_arbiter
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  instr_ram_arbiter_if.slave bus
);

  logic [1:0]              req;
  logic [1:0]              gnt_arb;
  logic [1:0]              gnt;
  logic                    p1_boot_wr;
  owner_e                  owner_q, owner_d;

  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH/8-1:0] ram_be;

  logic                    p0_rvalid;
  logic                    p1_rvalid;

  assign req[PORT_P0] = bus.p0_req_i;
  assign req[PORT_P1] = bus.p1_req_i;

`ifdef INSTR_ARB_RR_EN
  instr_rr_arb2 u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt_arb)
  );
`else
  always_comb begin
    gnt_arb = '0;
    if (req[PORT_P1])      gnt_arb[PORT_P1] = 1'b1;
    else if (req[PORT_P0]) gnt_arb[PORT_P0] = 1'b1;
  end
`endif

  // Grants are masked while reset is held so nothing reaches the RAM
  always_comb begin
    gnt        = rst_n ? gnt_arb : 2'b00;
    p1_boot_wr = gnt[PORT_P1] & bus.p1_we_i & bus.p1_addr_i[ADDR_WIDTH-1];
    owner_d    = OWN_IDLE;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_be     = '0;
    if (gnt[PORT_P0]) begin
      owner_d  = OWN_P0;
      ram_en   = 1'b1;
      ram_addr = bus.p0_addr_i;
      ram_be   = '1;
    end else if (gnt[PORT_P1]) begin
      if (p1_boot_wr) begin
        owner_d = OWN_P1_ERR;
      end else begin
        owner_d   = OWN_P1;
        ram_en    = 1'b1;
        ram_we    = bus.p1_we_i;
        ram_addr  = bus.p1_addr_i;
        ram_wdata = bus.p1_wdata_i;
        ram_be    = bus.p1_be_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= OWN_IDLE;
    else        owner_q <= owner_d;
  end

  assign p0_rvalid = (owner_q == OWN_P0);
  assign p1_rvalid = (owner_q == OWN_P1) || (owner_q == OWN_P1_ERR);

  assign bus.p0_gnt_o    = gnt[PORT_P0];
  assign bus.p1_gnt_o    = gnt[PORT_P1];
  assign bus.p0_rvalid_o = p0_rvalid;
  assign bus.p1_rvalid_o = p1_rvalid;
  assign bus.p1_err_o    = (owner_q == OWN_P1_ERR);
  assign bus.p0_rdata_o  = p0_rvalid ? bus.ram_rdata_i : '0;
  assign bus.p1_rdata_o  = (owner_q == OWN_P1) ? bus.ram_rdata_i : '0;

  assign bus.ram_en_o    = ram_en;
  assign bus.ram_we_o    = ram_we;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_wdata_o = ram_wdata;
  assign bus.ram_be_o    = ram_be;

endmodule

// File: doc/instr_ram_arbiter.md
INSTR_RAM_ARBITER -- requirements
Module: instr_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning instruction-memory address width; MSB set selects the boot ROM region.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports p0_req_i/p0_gnt_o  in/out  1  fetch port request/grant.
REQ-006 SHALL have port p0_addr_i  input  ADDR_WIDTH  fetch address; p0 is read-only.
REQ-007 SHALL have ports p0_rvalid_o  output  1  and p0_rdata_o  output  DATA_WIDTH  fetch response.
REQ-008 SHALL have ports p1_req_i/p1_gnt_o  in/out  1  loader/data port request/grant.
REQ-009 SHALL have ports p1_we_i  input  1, p1_be_i  input  DATA_WIDTH/8, p1_addr_i  input  ADDR_WIDTH, p1_wdata_i  input  DATA_WIDTH  loader access.
REQ-010 SHALL have ports p1_rvalid_o  output  1, p1_rdata_o  output  DATA_WIDTH, p1_err_o  output  1  loader response.
REQ-011 SHALL have ports ram_en_o, ram_we_o  output  1; ram_addr_o  output  ADDR_WIDTH; ram_wdata_o  output  DATA_WIDTH; ram_be_o  output  DATA_WIDTH/8  memory request.
REQ-012 SHALL have port ram_rdata_i  input  DATA_WIDTH  memory read data, valid one cycle after ram_en_o.

Function
REQ-013 SHALL grant at most one port per cycle; gnt is combinational from req in the same cycle; a granted cycle drives ram_en_o=1 with that port's fields.
REQ-014 SHALL drive p0 accesses with ram_we_o=0 and ram_be_o=all ones.
REQ-015 SHALL assert rvalid of the granted port exactly one cycle after grant, for reads and writes, regardless of req in that next cycle.
REQ-016 SHALL route ram_rdata_i to the rdata of the port whose rvalid is high; the other port's rdata is 0.
REQ-017 SHALL treat a p1 write with addr MSB=1 (boot region) as error: granted, ram_en_o=0, next cycle p1_rvalid_o=1, p1_err_o=1, p1_rdata_o=0.
REQ-018 SHALL hold p1_err_o=0 whenever p1_rvalid_o=0 or the access was not a boot-region write.
REQ-019 SHALL keep one response-owner register (IDLE, P0, P1, P1_ERR) updated every cycle from the current grant; IDLE when no grant.
REQ-020 SHALL issue back-to-back grants every cycle with no bubble; a single requester gets gnt every cycle.
REQ-021 SHALL drive ram_addr_o/wdata_o/be_o to 0 when ram_en_o=0.

Reset
REQ-022 SHALL on rst_n low force owner=IDLE, priority pointer=P0, all rvalid/err=0, all gnt=0, ram_en_o=0 immediately.
REQ-023 SHALL drop any response pending at reset assertion; none is issued after release.

Configuration
REQ-024 SHALL, with INSTR_ARB_RR_EN defined, arbitrate round-robin: on conflict grant the port not granted last conflict-free-or-not; pointer toggles only on a contested grant.
REQ-025 SHALL, without INSTR_ARB_RR_EN, use fixed priority p1 over p0; pointer register absent.

Structure
REQ-026 SHALL place owner-state enum (IDLE, P0, P1, P1_ERR) and port index constants in shared package instr_mem_pkg.
REQ-027 SHALL contain one sub-module instr_rr_arb2 (two-input arbiter with pointer), instantiated only under INSTR_ARB_RR_EN.
REQ-028 SHALL target 120-400 lines of RTL total.

Verification
REQ-029 SHALL test: p0 only, addr 0x0004,0x0008 on consecutive cycles -> gnt both cycles, rvalid cycles later +1 each, rdata = RAM contents.
REQ-030 SHALL test: both req every cycle, RR_EN -> grants alternate p0,p1,p0,p1; without RR_EN -> p1 granted every cycle, p0 never.
REQ-031 SHALL test: p1 write addr 0x8010 data 0xDEADBEEF -> ram_en_o=0, next cycle p1_rvalid_o=1, p1_err_o=1, RAM unchanged.
REQ-032 SHALL test: p1 write 0x0010 be=0011 data 0xAABBCCDD, then p0 read 0x0010 -> rdata low half 0xCCDD, upper half unchanged.
REQ-033 SHALL test: rst_n low one cycle after p0 grant -> no p0_rvalid_o ever; after release first contested grant goes to p0.
